// File: rtl/audio_rec_writer.sv
// ============================================================================
// Module      : audio_rec_writer
// Description : Capture-side sample writer for the audio path. Writes the
//               sample_valid_i stream into the sample RAM from address 0 and
//               stops at DEPTH or on stop_i. It then reports the recorded
//               length, which the playback counter uses when reading back.
// Config      : `AUDIO_REC_LOOP_EN
//                 defined   - circular recording: the pointer wraps at DEPTH-1
//                             and recording runs until stop_i. wrapped_o is
//                             set on the first wrap.
//                 undefined - one-shot recording: writing DEPTH-1 finishes.
//                             wrapped_o is tied to 0.
// Ports       : clk_i          system clock, rising edge
//               reset_i        synchronous active-high reset, returns to IDLE
//               start_i        pulse, begin a new recording
//               stop_i         pulse, end the current recording
//               sample_in_i    audio sample [DATA_W]
//               sample_valid_i sample_in_i valid this cycle
//               mem_we_o       RAM write enable, one pulse per sample
//               mem_addr_o     RAM write address [ADDR_W]
//               mem_din_o      RAM write data [DATA_W]
//               busy_o         recording in progress
//               done_o         recording finished
//               rec_len_o      samples stored [ADDR_W+1]
//               wrapped_o      buffer wrapped at least once (loop mode only)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_rec_writer #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 131072
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic [DATA_W-1:0] sample_in_i,
   input  logic              sample_valid_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_din_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W:0]   rec_len_o,
   output logic              wrapped_o
);

   localparam logic [ADDR_W-1:0] c_LAST     = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] c_PTR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   c_LEN_MAX  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   c_LEN_ONE  = (ADDR_W+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q,    state_d;
   logic [ADDR_W-1:0]   wr_ptr_q,   wr_ptr_d;
   logic [ADDR_W:0]     rec_len_q,  rec_len_d;
   logic                mem_we_q,   mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_din_q,  mem_din_d;
   logic                busy_q,     busy_d;
   logic                done_q,     done_d;
`ifdef AUDIO_REC_LOOP_EN
   logic                wrapped_q,  wrapped_d;
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rec_len_q  <= '0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef AUDIO_REC_LOOP_EN
         wrapped_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rec_len_q  <= rec_len_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef AUDIO_REC_LOOP_EN
         wrapped_q  <= wrapped_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rec_len_d  = rec_len_q;
      mem_we_d   = 1'b0;
      // Address and data hold their last write values between pulses.
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
`ifdef AUDIO_REC_LOOP_EN
      wrapped_d  = wrapped_q;
`endif

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d   = S_REC;
               wr_ptr_d  = '0;
               rec_len_d = '0;
`ifdef AUDIO_REC_LOOP_EN
               wrapped_d = 1'b0;
`endif
            end
         end
         S_REC: begin
            // stop_i outranks a coincident sample, which is dropped.
            if (stop_i) begin
               state_d = S_DONE;
            end else if (sample_valid_i) begin
               mem_we_d   = 1'b1;
               mem_addr_d = wr_ptr_q;
               mem_din_d  = sample_in_i;
               if (rec_len_q < c_LEN_MAX) begin
                  rec_len_d = rec_len_q + c_LEN_ONE;
               end
               if (wr_ptr_q == c_LAST) begin
`ifdef AUDIO_REC_LOOP_EN
                  wr_ptr_d  = '0;
                  wrapped_d = 1'b1;
`else
                  state_d   = S_DONE;
`endif
               end else begin
                  wr_ptr_d = wr_ptr_q + c_PTR_ONE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Status flags are registered from the next state, so they line up
      // with the state they describe.
      busy_d = (state_d == S_REC);
      done_d = (state_d == S_DONE);
   end

   assign mem_we_o   = mem_we_q;
   assign mem_addr_o = mem_addr_q;
   assign mem_din_o  = mem_din_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign rec_len_o  = rec_len_q;
`ifdef AUDIO_REC_LOOP_EN
   assign wrapped_o  = wrapped_q;
`else
   assign wrapped_o  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_audio_rec_writer.sv
// ============================================================================
// Module      : tb_audio_rec_writer
// Description : Directed self-checking bench for audio_rec_writer with
//               ADDR_W=3 and DEPTH=8 (a full address space). It covers one-shot
//               fill and, when `AUDIO_REC_LOOP_EN is defined, circular wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_audio_rec_writer;

   localparam int ADDR_W = 3;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic [DATA_W-1:0] sample_in = '0;
   logic              sample_valid = 1'b0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic              busy;
   logic              done;
   logic [ADDR_W:0]   rec_len;
   logic              wrapped;

   int total = 0;
   int bad   = 0;

   // Every RAM write seen mid-cycle, in order.
   int wr_addr_q[$];
   int wr_data_q[$];

   audio_rec_writer #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .start_i       (start),
      .stop_i        (stop),
      .sample_in_i   (sample_in),
      .sample_valid_i(sample_valid),
      .mem_we_o      (mem_we),
      .mem_addr_o    (mem_addr),
      .mem_din_o     (mem_din),
      .busy_o        (busy),
      .done_o        (done),
      .rec_len_o     (rec_len),
      .wrapped_o     (wrapped)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we) begin
         wr_addr_q.push_back(int'(mem_addr));
         wr_data_q.push_back(int'(mem_din));
      end
   end

   task automatic check_val(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   task automatic check_status(input string tag, input int we, input int b, input int d, input int len);
      check_val({tag, ".we"},      int'(mem_we),  we);
      check_val({tag, ".busy"},    int'(busy),    b);
      check_val({tag, ".done"},    int'(done),    d);
      check_val({tag, ".rec_len"}, int'(rec_len), len);
   endtask

   initial begin
      // Reset held for 2 cycles while start is pulsed.
      reset = 1'b1;
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      check_status("rst", 0, 0, 0, 0);
      check_val("rst.addr",    int'(mem_addr), 0);
      check_val("rst.din",     int'(mem_din),  0);
      check_val("rst.wrapped", int'(wrapped),  0);
      reset = 1'b0;
      sample_valid = 1'b1;
      stop = 1'b1;
      cyc();
      check_status("idle_ign", 0, 0, 0, 0);
      sample_valid = 1'b0;
      stop = 1'b0;
      check_val("rst.nwrites", wr_addr_q.size(), 0);

      // Basic write of three samples, then stop.
      clear_log();
      start = 1'b1;
      cyc();
      start = 1'b0;
      check_status("bw.start", 0, 1, 0, 0);
      sample_valid = 1'b1;
      sample_in = 8'h11; cyc();
      check_val("bw.w0.addr", int'(mem_addr), 0);
      check_status("bw.w0", 1, 1, 0, 1);
      sample_in = 8'h22; cyc();
      sample_in = 8'h33; cyc();
      check_val("bw.w2.addr", int'(mem_addr), 2);
      check_val("bw.w2.din",  int'(mem_din),  8'h33);
      check_status("bw.w2", 1, 1, 0, 3);
      sample_valid = 1'b0;
      stop = 1'b1; cyc();
      stop = 1'b0;
      check_status("bw.stop", 0, 0, 1, 3);
      check_val("bw.hold.addr", int'(mem_addr), 2);
      check_val("bw.nwrites", wr_addr_q.size(), 3);
      for (int i = 0; i < wr_addr_q.size(); i++) begin
         check_val($sformatf("bw.log%0d.addr", i), wr_addr_q[i], i);
         check_val($sformatf("bw.log%0d.data", i), wr_data_q[i], 8'h11 * (i + 1));
      end

      // Restart from DONE, then stop outranks a coincident sample.
      clear_log();
      start = 1'b1; cyc();
      start = 1'b0;
      check_status("rs.start", 0, 1, 0, 0);
      sample_valid = 1'b1;
      sample_in = 8'h44; cyc();
      check_val("rs.w0.addr", int'(mem_addr), 0);
      check_val("rs.w0.din",  int'(mem_din),  8'h44);
      sample_in = 8'h55; cyc();
      stop = 1'b1;
      sample_in = 8'hAA; cyc();
      stop = 1'b0;
      sample_valid = 1'b0;
      check_status("sp", 0, 0, 1, 2);
      check_val("sp.din_hold", int'(mem_din), 8'h55);
      cyc();
      check_val("sp.nwrites", wr_addr_q.size(), 2);
      check_val("sp.last", wr_data_q[wr_data_q.size()-1], 8'h55);

      // Reset in the middle of a recording.
      clear_log();
      start = 1'b1; cyc();
      start = 1'b0;
      sample_valid = 1'b1;
      sample_in = 8'h01; cyc();
      sample_in = 8'h02; cyc();
      reset = 1'b1;
      sample_in = 8'h03; cyc();
      check_status("mr", 0, 0, 0, 0);
      reset = 1'b0;
      sample_in = 8'h04; cyc();
      check_status("mr.idle", 0, 0, 0, 0);
      sample_valid = 1'b0;
      check_val("mr.nwrites", wr_addr_q.size(), 2);

      // Fill to depth with 10 samples.
      clear_log();
      start = 1'b1; cyc();
      start = 1'b0;
      sample_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         sample_in = DATA_W'(i);
         cyc();
`ifdef AUDIO_REC_LOOP_EN
         check_val($sformatf("lp.s%0d.addr", i), int'(mem_addr), i % DEPTH);
         check_status($sformatf("lp.s%0d", i), 1, 1, 0, (i + 1 > DEPTH) ? DEPTH : i + 1);
         check_val($sformatf("lp.s%0d.wrapped", i), int'(wrapped), (i >= DEPTH - 1) ? 1 : 0);
`else
         if (i == DEPTH - 1) begin
            check_val("fill.last.addr", int'(mem_addr), DEPTH - 1);
            check_status("fill.last", 1, 0, 1, DEPTH);
         end else if (i >= DEPTH) begin
            check_status($sformatf("fill.post%0d", i), 0, 0, 1, DEPTH);
         end
`endif
      end
      sample_valid = 1'b0;
`ifdef AUDIO_REC_LOOP_EN
      stop = 1'b1; cyc();
      stop = 1'b0;
      check_status("lp.stop", 0, 0, 1, DEPTH);
      check_val("lp.wrapped_held", int'(wrapped), 1);
`else
      check_val("fill.wrapped", int'(wrapped), 0);
`endif
      cyc();
`ifdef AUDIO_REC_LOOP_EN
      check_val("lp.nwrites", wr_addr_q.size(), 10);
`else
      check_val("fill.nwrites", wr_addr_q.size(), DEPTH);
`endif
      for (int i = 0; i < wr_addr_q.size(); i++) begin
         check_val($sformatf("fill.log%0d.addr", i), wr_addr_q[i], i % DEPTH);
         check_val($sformatf("fill.log%0d.data", i), wr_data_q[i], i);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/audio_rec_writer.md
# audio_rec_writer

- Capture-side counterpart of the playback address counter in the audio path.
- Accepts a stream of audio samples under a valid strobe and writes them sequentially into the sample RAM, starting at address 0.
- Stops at the configured depth or on command, then reports how many samples were recorded.
- The playback counter later reads the same RAM back.

## Interface
- ADDR_W, 17, sample RAM address width (matches playback counter width)
- DATA_W, 8, sample width
- DEPTH, 131072, number of usable RAM words; 1 ≤ DEPTH ≤ 2^ADDR_W; last address = DEPTH-1

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE
- start  in  1  single-cycle pulse: begin a new recording
- stop  in  1  single-cycle pulse: end current recording
- sample_in  in  DATA_W  audio sample
- sample_valid  in  1  sample_in valid this cycle (one sample per high cycle)
- mem_we  out  1  RAM write enable, one-cycle pulse per sample
- mem_addr  out  ADDR_W  RAM write address
- mem_din  out  DATA_W  RAM write data
- busy  out  1  high while in REC
- done  out  1  high while in DONE
- rec_len  out  ADDR_W+1  samples stored in last/current recording
- wrapped  out  1  loop mode only: buffer wrapped at least once (constant 0 otherwise)

## Operation
- All outputs are registered.
- Reset values: mem_we=0, mem_addr=0, mem_din=0, busy=0, done=0, rec_len=0, wrapped=0, state=IDLE, wr_ptr=0.
- States:
  - **IDLE**: busy=0, done=0. start=1 → REC; wr_ptr←0, rec_len←0, wrapped←0. sample_valid and stop are ignored.
  - **REC**: busy=1. Evaluated each cycle, in this priority order:
    1. stop=1 → DONE. A sample valid in the same cycle is discarded.
    2. sample_valid=1 → write sample_in at wr_ptr; rec_len increments (saturates at DEPTH).
       - If wr_ptr < DEPTH-1: wr_ptr increments.
       - If wr_ptr = DEPTH-1 in non-loop mode: this is the final write, → DONE.
       - If wr_ptr = DEPTH-1 in loop mode: wr_ptr←0, wrapped←1, stay in REC.
    - start while in REC is ignored.
  - **DONE**: done=1, busy=0. rec_len and wrapped are held. start=1 → REC with the same clearing as from IDLE; done drops on the next cycle. stop is ignored.
- Arithmetic:
  - wr_ptr is ADDR_W bits and never exceeds DEPTH-1.
  - rec_len is ADDR_W+1 bits, so a full 2^17-sample recording reports 131072.
- Reset asserted mid-recording: next-edge return to IDLE; mem_we=0 on that edge. RAM contents are untouched.

## Timing
- Sample accepted at rising edge N (sample_valid=1, state REC, stop=0).
  - mem_we=1, mem_addr=wr_ptr, mem_din=sample_in are valid during the cycle after edge N.
  - mem_we returns to 0 after one cycle unless another sample is accepted.
- Back-to-back sample_valid is supported at full clock rate: consecutive mem_we pulses at addresses k, k+1, ...
- mem_addr and mem_din hold their last write values while mem_we=0.
- start at edge N: busy=1 after edge N; first sample can be accepted at edge N+1.
- Final write (non-loop) at edge N: mem_we=1 and done=1, busy=0 in the same following cycle.
- stop at edge N: busy=0, done=1 after edge N. No mem_we after edge N.
- rec_len updates in the same cycle as the corresponding mem_we.

## Configuration
- Macro: `AUDIO_REC_LOOP_EN`.
- Defined: circular recording. At DEPTH-1 the pointer wraps to 0 and recording continues until stop. wrapped is set on the first wrap. rec_len saturates at DEPTH.
- Undefined: one-shot recording. Writing address DEPTH-1 ends the recording (→ DONE). wrapped is tied to 0 and the wrap logic is absent.

## Test plan
- Reset check: reset=1 for 2 cycles with start pulsing → all outputs 0, state IDLE; mem_we never asserted.
- Basic write (DEPTH=8): start, then samples 0x11, 0x22, 0x33 on consecutive cycles, then stop → mem_we pulses at addresses 0, 1, 2 with those data; done=1; rec_len=3.
- Fill to depth, non-loop (DEPTH=8): 10 valid samples 0x00..0x09 → writes at addresses 0..7 only; done=1 in the cycle of the write to 7; rec_len=8; samples 0x08 and 0x09 are not written.
- Stop priority: stop and sample_valid (0xAA) in the same cycle after 2 samples → no write of 0xAA; rec_len=2; done=1.
- Loop mode (AUDIO_REC_LOOP_EN, DEPTH=4): 6 samples then stop → addresses 0, 1, 2, 3, 0, 1; wrapped=1; rec_len=4; busy until stop.
- Restart and mid-reset: from DONE (rec_len=3), start → rec_len=0, done=0, next write at address 0. Reset asserted after 2 writes → IDLE next cycle, no further mem_we.
